icache_controller: RTL

Instruction-cache controller and fill engine for the fetch stage. It translates the fetch address into index/tag lookups on the 128x64 cache data store and returns hit data to fetch. On a miss it issues `BUS_LOAD` requests to memory, tracking up to NUM_MSHR outstanding misses in a tag-matched miss table. When memory returns tagged data, it writes the line into the cache data store through that store's single write port.

---
 rtl/icache_controller_if.sv | 59 +++++
 rtl/icache_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/icache_controller_if.sv
// Fetch/cache-store/memory bundle between the fetch stage, the cache data
// store, the memory bus and the icache controller.

`ifndef ICACHE_IDX_BITS
`define ICACHE_IDX_BITS 7
`endif
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS (64 - `ICACHE_IDX_BITS - 3)
`endif
`ifndef BUS_NONE
`define BUS_NONE 2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD 2'h1
`endif

interface icache_controller_if;
    // Fetch side
    logic                        fetch_en;
    logic [63:0]                 proc2Icache_addr;
    logic [63:0]                 Icache_data_out;
    logic                        Icache_valid_out;
    // Cache data store read port
    logic [`ICACHE_IDX_BITS-1:0] rd1_idx;
    logic [`ICACHE_TAG_BITS-1:0] rd1_tag;
    logic [63:0]                 rd1_data;
    logic                        rd1_valid;
    // Cache data store write port
    logic                        wr1_en;
    logic [`ICACHE_IDX_BITS-1:0] wr1_idx;
    logic [`ICACHE_TAG_BITS-1:0] wr1_tag;
    logic [63:0]                 wr1_data;
    // Memory bus
    logic [1:0]                  proc2mem_command;
    logic [63:0]                 proc2mem_addr;
    logic [3:0]                  mem2proc_response;
    logic [63:0]                 mem2proc_data;
    logic [3:0]                  mem2proc_tag;
    // Status
    logic                        mshr_full;

    // Controller side
    modport slave (
        input  fetch_en, proc2Icache_addr, rd1_data, rd1_valid,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output Icache_data_out, Icache_valid_out, rd1_idx, rd1_tag,
               wr1_en, wr1_idx, wr1_tag, wr1_data,
               proc2mem_command, proc2mem_addr, mshr_full
    );

    // Environment side (fetch, store and memory)
    modport master (
        output fetch_en, proc2Icache_addr, rd1_data, rd1_valid,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  Icache_data_out, Icache_valid_out, rd1_idx, rd1_tag,
               wr1_en, wr1_idx, wr1_tag, wr1_data,
               proc2mem_command, proc2mem_addr, mshr_full
    );
endinterface

// File: rtl/icache_controller.sv
// Instruction-cache controller: combinational lookup into the cache data
// store, miss request generation, and a tag-matched miss table that turns
// returning memory data into fill writes.

`ifndef ICACHE_IDX_BITS
`define ICACHE_IDX_BITS 7
`endif
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS (64 - `ICACHE_IDX_BITS - 3)
`endif
`ifndef BUS_NONE
`define BUS_NONE 2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD 2'h1
`endif

module icache_controller #(
    parameter int unsigned NUM_MSHR = 4
) (
    input logic                 clock,
    input logic                 reset,
    icache_controller_if.slave  bus
);

    localparam int unsigned IdxW = `ICACHE_IDX_BITS;
    localparam int unsigned TagW = `ICACHE_TAG_BITS;

    // Miss table
    logic [NUM_MSHR-1:0]           valid_q, valid_d;
    logic [NUM_MSHR-1:0][3:0]      mem_tag_q, mem_tag_d;
    logic [NUM_MSHR-1:0][IdxW-1:0] idx_q, idx_d;
    logic [NUM_MSHR-1:0][TagW-1:0] tag_q, tag_d;

    logic [IdxW-1:0]     cur_idx;
    logic [TagW-1:0]     cur_tag;
    logic [NUM_MSHR-1:0] comp_oh;
    logic [NUM_MSHR-1:0] free_oh;
    logic                comp_hit;
    logic                pending;
    logic                full;
    logic                req;
    logic                alloc;
    logic                unused_addr;

    assign cur_idx     = bus.proc2Icache_addr[IdxW+2:3];
    assign cur_tag     = bus.proc2Icache_addr[63:IdxW+3];
    assign unused_addr = ^bus.proc2Icache_addr[2:0];

    // Table search: lowest completing entry, lowest free entry, duplicate check
    always_comb begin
        logic comp_found;
        logic free_found;
        comp_oh    = '0;
        free_oh    = '0;
        pending    = 1'b0;
        comp_found = 1'b0;
        free_found = 1'b0;
        for (int i = 0; i < int'(NUM_MSHR); i++) begin
            if (!comp_found && valid_q[i] && (bus.mem2proc_tag != 4'd0) &&
                (mem_tag_q[i] == bus.mem2proc_tag)) begin
                comp_oh[i] = 1'b1;
                comp_found = 1'b1;
            end
            // Free is judged on the registered state, so a slot completing now
            // is not reused until next cycle.
            if (!free_found && !valid_q[i]) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
            // Completing entries still count, which blocks a re-request in the
            // fill cycle (the store only updates at the end of it).
            if (valid_q[i] && (idx_q[i] == cur_idx) && (tag_q[i] == cur_tag)) begin
                pending = 1'b1;
            end
        end
        comp_hit = |comp_oh;
        full     = &valid_q;
        req      = bus.fetch_en && !bus.rd1_valid && !pending && !full && !reset;
        alloc    = req && (bus.mem2proc_response != 4'd0);
    end

    // Next table state: clear the completing entry, then fill the free slot
    always_comb begin
        valid_d   = valid_q;
        mem_tag_d = mem_tag_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        if (comp_hit) begin
            valid_d = valid_d & ~comp_oh;
        end
        if (alloc) begin
            for (int i = 0; i < int'(NUM_MSHR); i++) begin
                if (free_oh[i]) begin
                    valid_d[i]   = 1'b1;
                    mem_tag_d[i] = bus.mem2proc_response;
                    idx_d[i]     = cur_idx;
                    tag_d[i]     = cur_tag;
                end
            end
        end
    end

    // Table registers; reset drops every outstanding miss immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            mem_tag_q <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            mem_tag_q <= mem_tag_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
        end
    end

    // Outputs: lookup, memory request and fill write
    always_comb begin
        bus.rd1_idx          = cur_idx;
        bus.rd1_tag          = cur_tag;
        bus.Icache_data_out  = bus.rd1_data;
        bus.Icache_valid_out = bus.fetch_en && bus.rd1_valid && !reset;
        bus.proc2mem_command = req ? `BUS_LOAD : `BUS_NONE;
        bus.proc2mem_addr    = {bus.proc2Icache_addr[63:3], 3'b000};
        bus.mshr_full        = full;
        bus.wr1_en           = comp_hit && !reset;
        bus.wr1_data         = bus.mem2proc_data;
        bus.wr1_idx          = '0;
        bus.wr1_tag          = '0;
        for (int i = 0; i < int'(NUM_MSHR); i++) begin
            if (comp_oh[i]) begin
                bus.wr1_idx = idx_q[i];
                bus.wr1_tag = tag_q[i];
            end
        end
    end

endmodule
